// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// per-grant hold limit with forced release, and fully registered outputs.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mode,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] gnt_id_nx;
  logic       valid_nx;
  logic       timeout_nx;
  logic [3:0] hold, hold_nx;
  logic [1:0] last, last_nx;
  logic [1:0] win_fixed, win_rr, win;
  logic       rr_found;

  // Fixed priority: the last asserted bit scanned upward wins, i.e. the highest index.
  always_comb begin
    win_fixed = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (req[i]) win_fixed = 2'(i);
  end

  // Round-robin: scan last+1 .. last+4 (mod 4); the final step revisits last itself.
  always_comb begin
    logic [1:0] cand;
    win_rr   = last;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!rr_found && req[cand]) begin
        win_rr   = cand;
        rr_found = 1'b1;
      end
    end
  end

  assign win = mode ? win_rr : win_fixed;

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    gnt_id_nx  = gnt_id;
    valid_nx   = valid;
    timeout_nx = 1'b0;
    hold_nx    = hold;
    last_nx    = last;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx  = BUSY;
          grant_nx  = 4'b0001 << win;
          gnt_id_nx = win;
          valid_nx  = 1'b1;
          hold_nx   = '0;
          last_nx   = win;
        end else begin
          grant_nx  = '0;
          gnt_id_nx = '0;
          valid_nx  = 1'b0;
        end
      end
      BUSY: begin
        if (done || !req[gnt_id] || (hold == HOLD_LIM)) begin
          state_nx   = IDLE;
          grant_nx   = '0;
          gnt_id_nx  = '0;
          valid_nx   = 1'b0;
          // Forced release only when the hold limit alone ends the grant.
          timeout_nx = !done && req[gnt_id];
        end else if (hold != 4'hF) begin
          hold_nx = hold + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_id  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      hold    <= '0;
      last    <= 2'd3;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      gnt_id  <= gnt_id_nx;
      valid   <= valid_nx;
      timeout <= timeout_nx;
      hold    <= hold_nx;
      last    <= last_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed, table-driven bench for rr_arbiter4 (default hold limit) plus
// hand-written sequences for hold-limit release and asynchronous reset.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n, rst_b;
  logic [3:0] req, req_b;
  logic       mode, mode_b, done, done_b;
  logic [3:0] grant, grant_b;
  logic [1:0] gnt_id, gnt_id_b;
  logic       valid, valid_b, timeout, timeout_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arbiter4 dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .done(done),
    .grant(grant), .gnt_id(gnt_id), .valid(valid), .timeout(timeout)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .mode(mode_b), .done(done_b),
    .grant(grant_b), .gnt_id(gnt_id_b), .valid(valid_b), .timeout(timeout_b)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       mode;
    logic       done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic       timeout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic m, input logic d,
                     input logic [3:0] g, input logic [1:0] id, input logic v, input logic t);
    vec_t x;
    x.rst_n = r; x.req = rq; x.mode = m; x.done = d;
    x.grant = g; x.id = id; x.valid = v; x.timeout = t;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {grant,id,valid,timeout}=%b expected %b", nm, got, exp);
    end
  endtask

  function automatic logic inv_ok(input logic [3:0] g, input logic [1:0] id, input logic v);
    logic onehot0;
    onehot0 = ((g & (g - 4'd1)) == 4'd0);
    if (v) return onehot0 && (g == (4'b0001 << id));
    return (g == 4'd0) && (id == 2'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_a", {7'd0, inv_ok(grant, gnt_id, valid)}, 8'd1);
    chk("inv_b", {7'd0, inv_ok(grant_b, gnt_id_b, valid_b)}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mode = 1'b0; done = 1'b0;
    rst_b = 1'b0; req_b = '0; mode_b = 1'b0; done_b = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // fixed priority, done release, IDLE gap then re-grant
    add(1, 4'b1011, 0, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1011, 0, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1011, 0, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1011, 0, 1, 4'b0000, 0, 0, 0);
    // round-robin rotation from reset (last=3)
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 4'b0010, 1, 1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    // rr from last=0 picks 1; mode flip in BUSY ignored; fixed picks 2
    add(1, 4'b0110, 1, 0, 4'b0010, 1, 1, 0);
    add(1, 4'b0110, 0, 0, 4'b0010, 1, 1, 0);
    add(1, 4'b0110, 0, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b0110, 0, 0, 4'b0100, 2, 1, 0);
    // non-owner req changes do not disturb grant; owner drop releases
    add(1, 4'b1111, 0, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 0, 0, 4'b0100, 2, 1, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // rr after fixed grant: last=2 so 3 wins, then 0
    add(1, 4'b1001, 1, 0, 4'b1000, 3, 1, 0);
    add(1, 4'b1001, 1, 1, 4'b0000, 0, 0, 0);
    add(1, 4'b1001, 1, 0, 4'b0001, 0, 1, 0);
    add(1, 4'b1000, 1, 0, 4'b0000, 0, 0, 0);
    // owner 1 drops its request
    add(1, 4'b1010, 1, 0, 4'b0010, 1, 1, 0);
    add(1, 4'b1000, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);

    #2;
    chk("reset_a", {grant, gnt_id, valid, timeout}, 8'd0);
    chk("reset_b", {grant_b, gnt_id_b, valid_b, timeout_b}, 8'd0);
    tick();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; req = vecs[i].req; mode = vecs[i].mode; done = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i), {grant, gnt_id, valid, timeout},
          {vecs[i].grant, vecs[i].id, vecs[i].valid, vecs[i].timeout});
    end

    // async reset during BUSY drops grant before any clock edge
    req = 4'b0100; mode = 1'b0; done = 1'b0;
    tick();
    chk("pre_rst", {grant, gnt_id, valid, timeout}, {4'b0100, 2'd2, 1'b1, 1'b0});
    #3 rst_n = 1'b0;
    #1 chk("async_rst", {grant, gnt_id, valid, timeout}, 8'd0);
    req = 4'b0010;
    tick();
    chk("in_rst", {grant, gnt_id, valid, timeout}, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("first_arb", {grant, gnt_id, valid, timeout}, {4'b0010, 2'd1, 1'b1, 1'b0});
    done = 1'b1;
    tick();
    done = 1'b0; req = '0;

    // MAX_HOLD=4: four grant cycles, then a single timeout pulse
    rst_b = 1'b1; req_b = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("hold%0d", c), {grant_b, gnt_id_b, valid_b, timeout_b}, {4'b0100, 2'd2, 1'b1, 1'b0});
    end
    tick();
    chk("timeout", {grant_b, gnt_id_b, valid_b, timeout_b}, {4'b0000, 2'd0, 1'b0, 1'b1});
    tick();
    chk("regrant", {grant_b, gnt_id_b, valid_b, timeout_b}, {4'b0100, 2'd2, 1'b1, 1'b0});
    for (int c = 0; c < 3; c++) tick();
    done_b = 1'b1;
    tick();
    chk("done_at_lim", {grant_b, gnt_id_b, valid_b, timeout_b}, 8'd0);
    done_b = 1'b0;
    tick();
    chk("regrant2", {grant_b, gnt_id_b, valid_b, timeout_b}, {4'b0100, 2'd2, 1'b1, 1'b0});
    for (int c = 0; c < 3; c++) tick();
    #3 rst_b = 1'b0;
    #1 chk("async_rst_b", {grant_b, gnt_id_b, valid_b, timeout_b}, 8'd0);
    tick();
    chk("no_to_rst", {grant_b, gnt_id_b, valid_b, timeout_b}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15 (range 1..15): maximum number of cycles a grant is held before forced release.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: one request line per requester 0..3.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = fixed priority, 1 = round-robin; sampled only in IDLE.
REQ-006 The block SHALL have port done, input, 1 bit: current owner releases the resource.
REQ-007 The block SHALL have port grant, output, 4 bits: one-hot grant; all zero when no owner.
REQ-008 The block SHALL have port gnt_id, output, 2 bits: binary index of the current owner; 0 when valid=0.
REQ-009 The block SHALL have port valid, output, 1 bit: high while any grant bit is high.
REQ-010 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and BUSY; all outputs SHALL be registered.
REQ-012 In IDLE with req != 0, the block SHALL select a winner, enter BUSY, and assert grant/gnt_id/valid on the next rising edge (1-cycle latency).
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with grant=0, gnt_id=0, valid=0.
REQ-014 mode=0: the winner SHALL be the highest-index asserted req bit (3 beats 2 beats 1 beats 0).
REQ-015 mode=1: the search order SHALL be last+1, last+2, last+3, last (mod 4), where last is the most recent owner, and the first asserted bit in that order SHALL win.
REQ-016 The register last SHALL update to the winner index on every grant, in both modes.
REQ-017 In BUSY, grant SHALL stay constant while req changes on non-owner lines.
REQ-018 In BUSY, release SHALL occur when done=1, when req[owner]=0, or when the hold counter equals MAX_HOLD-1; on release the block SHALL return to IDLE and clear grant/gnt_id/valid on the next edge.
REQ-019 The hold counter (4 bits) SHALL clear to 0 on grant and increment each BUSY cycle; it SHALL NOT wrap.
REQ-020 timeout SHALL pulse high for exactly one cycle, coincident with the grant-clear edge, only when the release is caused solely by the hold counter (done=0 and req[owner]=1).
REQ-021 Simultaneous done and counter limit SHALL count as a normal release (timeout=0).
REQ-022 After any release, the block SHALL spend at least one cycle in IDLE with valid=0 before the next grant, including a re-grant to the same requester.
REQ-023 A change of mode while in BUSY SHALL have no effect until the next IDLE arbitration.
REQ-024 At all times grant SHALL be zero or one-hot, and grant SHALL equal 1<<gnt_id whenever valid=1.

Reset
REQ-025 While rst_n=0, the block SHALL be in state IDLE with grant=0, gnt_id=0, valid=0, timeout=0, hold counter=0, and last=3, asynchronously.
REQ-026 Reset asserted during BUSY SHALL drop grant immediately, without waiting for a clock edge, and SHALL not pulse timeout.
REQ-027 After rst_n rises, the first arbitration SHALL occur on the first rising edge at which req != 0.

Verification
REQ-028 Reset then req=4'b0000 for 5 cycles -> valid=0, grant=0000, gnt_id=0 throughout.
REQ-029 mode=0, req=4'b1011 -> one cycle later grant=1000, gnt_id=3; then done=1 -> next edge grant=0000; one IDLE cycle; then grant=1000 again.
REQ-030 mode=1 after reset, req=4'b1111 held, done pulsed each BUSY cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with an IDLE gap between each.
REQ-031 MAX_HOLD=4, req=4'b0100 held, done=0 -> grant=0100 for exactly 4 cycles, then timeout=1 for one cycle with grant=0000.
REQ-032 Owner 1 drops req[1] in BUSY -> grant cleared on the next edge with timeout=0; rst_n pulled low mid-BUSY -> grant=0000 before the next clock edge.
REQ-033 Every test SHALL check grant is one-hot or zero and grant==1<<gnt_id when valid=1, on every cycle.
